alu_ex_stage: RTL and testbench

Execute stage of the 5-stage MIPS datapath, directly downstream of the ALU decoder. It accepts the decoded `ALUop` together with operand values and destination register, and performs the ALU operation. The result is held in a one-entry output register with a valid/ready handshake toward the memory stage. It supports pipeline flush and, optionally, EX→EX forwarding from its own output register.

---
 rtl/alu_ex_stage.sv | 154 +++++++++++++++
 tb/tb_alu_ex_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_ex_stage
// Purpose  : MIPS execute stage. Computes the decoded ALU operation and holds
//            the result in a one-entry output register with a valid/ready
//            handshake toward the memory stage. Supports flush.
// Options  : ALU_EX_FWD_EN - when defined, operands A/B are forwarded from the
//            stage's own output register (EX->EX bypass).
// Revision : 1.0 - initial release
// ============================================================================
module alu_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    ALUop,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [4:0]    shamt,
  input  logic          use_shamt,
  input  logic [RW-1:0] rs_idx,
  input  logic [RW-1:0] rt_idx,
  input  logic          b_is_reg,
  input  logic [RW-1:0] rd,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] result,
  output logic [RW-1:0] out_rd,
  output logic          out_illegal
);

  // ALU operation encoding (mirrors ALUop.vh); codes 12..14 are unassigned.
  localparam logic [3:0] ALU_ADDU = 4'd0;
  localparam logic [3:0] ALU_SUBU = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_XXX  = 4'd15;

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] result_q,    result_d;
  logic [RW-1:0] out_rd_q,    out_rd_d;
  logic          illegal_q,   illegal_d;

  logic          xfer;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [4:0]    sh;
  logic [DW-1:0] alu_res;
  logic          alu_ill;

  // Ready depends only on the output register state and downstream ready.
  assign in_ready = !out_valid_q || out_ready;
  assign xfer     = in_valid && in_ready && !flush;

`ifdef ALU_EX_FWD_EN
  logic fwd_a;
  logic fwd_b;

  // Bypass the held result into the operands when it targets a live source.
  always_comb begin
    fwd_a = out_valid_q && (out_rd_q != '0) && (out_rd_q == rs_idx);
    fwd_b = out_valid_q && (out_rd_q != '0) && (out_rd_q == rt_idx) && b_is_reg;
    op_a  = fwd_a ? result_q : a;
    op_b  = fwd_b ? result_q : b;
  end
`else
  // Source indices only matter for forwarding; fold them away here.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{rs_idx, rt_idx, b_is_reg};

  // Operands pass straight through without forwarding.
  always_comb begin
    op_a = a;
    op_b = b;
  end
`endif

  // Variable shifts take their amount from the low bits of operand A.
  assign sh = use_shamt ? shamt : op_a[4:0];

  // ALU operation select; unlisted codes yield zero and flag illegal.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (ALUop)
      ALU_ADDU: alu_res = op_a + op_b;
      ALU_SUBU: alu_res = op_a - op_b;
      ALU_SLT:  alu_res = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_res = {{(DW-1){1'b0}}, (op_a < op_b)};
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_NOR:  alu_res = ~(op_a | op_b);
      ALU_SLL:  alu_res = op_b << sh;
      ALU_SRL:  alu_res = op_b >> sh;
      ALU_SRA:  alu_res = $unsigned($signed(op_b) >>> sh);
      ALU_LUI:  alu_res = {op_b[15:0], 16'h0000};
      ALU_XXX:  alu_ill = 1'b1;
      default:  alu_ill = 1'b1;
    endcase
  end

  // Next state of the output register: flush kills, transfer loads, drain clears valid.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    out_rd_d    = out_rd_q;
    illegal_d   = illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (xfer) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      out_rd_d    = rd;
      illegal_d   = alu_ill;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_rd_q    <= '0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      out_rd_q    <= out_rd_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign out_rd      = out_rd_q;
  assign out_illegal = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_ex_stage
// Purpose  : Directed self-checking bench for alu_ex_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_ex_stage;

  localparam logic [3:0] ALU_ADDU = 4'd0;
  localparam logic [3:0] ALU_SUBU = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_XXX  = 4'd15;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUop;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic        use_shamt;
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
  logic        b_is_reg;
  logic [4:0]  rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int total = 0;
  int bad   = 0;

  alu_ex_stage #(.DW(32), .RW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUop      (ALUop),
    .a          (a),
    .b          (b),
    .shamt      (shamt),
    .use_shamt  (use_shamt),
    .rs_idx     (rs_idx),
    .rt_idx     (rt_idx),
    .b_is_reg   (b_is_reg),
    .rd         (rd),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .out_rd     (out_rd),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction (no clock advance).
  task automatic drive(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                       input logic [4:0] sa, input logic us, input logic [4:0] vrd,
                       input logic [4:0] rs, input logic [4:0] rt, input logic breg);
    in_valid  = 1'b1;
    ALUop     = op;
    a         = va;
    b         = vb;
    shamt     = sa;
    use_shamt = us;
    rd        = vrd;
    rs_idx    = rs;
    rt_idx    = rt;
    b_is_reg  = breg;
  endtask

  // Issue one instruction for a single cycle, then drop in_valid.
  task automatic issue(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                       input logic [4:0] sa, input logic us, input logic [4:0] vrd);
    drive(op, va, vb, sa, us, vrd, 5'd0, 5'd0, 1'b0);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; ALUop = '0; a = '0; b = '0; shamt = '0;
    use_shamt = 1'b0; rs_idx = '0; rt_idx = '0; b_is_reg = 1'b0; rd = '0;
    flush = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_valid",   {31'd0, out_valid},   32'd0);
    check("rst_result",  result,               32'd0);
    check("rst_rd",      {27'd0, out_rd},      32'd0);
    check("rst_illegal", {31'd0, out_illegal}, 32'd0);
    check("rst_ready",   {31'd0, in_ready},    32'd1);

    // ADDU wraparound
    issue(ALU_ADDU, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0, 5'd3);
    check("addu_res",     result,               32'd0);
    check("addu_valid",   {31'd0, out_valid},   32'd1);
    check("addu_illegal", {31'd0, out_illegal}, 32'd0);
    check("addu_rd",      {27'd0, out_rd},      32'd3);
    step();
    check("drain_valid",  {31'd0, out_valid},   32'd0);
    check("drain_hold",   result,               32'd0);

    // Directed ALU vectors
    issue(ALU_SRA,  32'd0,         32'h8000_0000, 5'd4, 1'b1, 5'd1);
    check("sra",  result, 32'hF800_0000);
    issue(ALU_SRL,  32'd36,        32'h8000_0000, 5'd0, 1'b0, 5'd1);
    check("srlv", result, 32'h0800_0000);
    issue(ALU_SLT,  32'hFFFF_FFFF, 32'd0,         5'd0, 1'b0, 5'd1);
    check("slt",  result, 32'd1);
    issue(ALU_SLTU, 32'hFFFF_FFFF, 32'd0,         5'd0, 1'b0, 5'd1);
    check("sltu", result, 32'd0);
    issue(ALU_SUBU, 32'd5,         32'd7,         5'd0, 1'b0, 5'd1);
    check("subu", result, 32'hFFFF_FFFE);
    issue(ALU_NOR,  32'h0F0F_0000, 32'h0000_00F0, 5'd0, 1'b0, 5'd1);
    check("nor",  result, 32'hF0F0_FF0F);
    issue(ALU_LUI,  32'd0,         32'h1234_ABCD, 5'd0, 1'b0, 5'd1);
    check("lui",  result, 32'hABCD_0000);
    issue(ALU_SLL,  32'd0,         32'h0000_0003, 5'd31, 1'b1, 5'd1);
    check("sll",  result, 32'h8000_0000);

    // Illegal codes
    issue(ALU_XXX, 32'h1111_1111, 32'h2222_2222, 5'd0, 1'b0, 5'd2);
    check("xxx_res", result, 32'd0);
    check("xxx_ill", {31'd0, out_illegal}, 32'd1);
    issue(4'd12,   32'h1111_1111, 32'h2222_2222, 5'd0, 1'b0, 5'd2);
    check("op12_ill", {31'd0, out_illegal}, 32'd1);

    // Back-to-back throughput: two accepts on consecutive edges
    drive(ALU_ADDU, 32'd10, 32'd20, 5'd0, 1'b0, 5'd4, 5'd0, 5'd0, 1'b0);
    step();
    check("b2b_1", result, 32'd30);
    drive(ALU_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0, 1'b0, 5'd6, 5'd0, 5'd0, 1'b0);
    step();
    in_valid = 1'b0;
    check("b2b_2",     result,             32'hF0F0_F0F0);
    check("b2b_valid", {31'd0, out_valid}, 32'd1);
    check("b2b_rd",    {27'd0, out_rd},    32'd6);
    step();

    // Stall: held result stays put while the next op waits
    out_ready = 1'b0;
    issue(ALU_ADDU, 32'd1, 32'd2, 5'd0, 1'b0, 5'd7);
    check("stall_load", result, 32'd3);
    drive(ALU_XOR, 32'hAAAA_AAAA, 32'h5555_5555, 5'd0, 1'b0, 5'd8, 5'd0, 5'd0, 1'b0);
    #1;
    check("stall_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_res",   result,             32'd3);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("unstall_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("swap_res",   result,             32'hFFFF_FFFF);
    check("swap_valid", {31'd0, out_valid}, 32'd1);
    check("swap_rd",    {27'd0, out_rd},    32'd8);
    step();

    // Flush with a held result and a concurrent input
    out_ready = 1'b0;
    issue(ALU_ADDU, 32'd100, 32'd1, 5'd0, 1'b0, 5'd9);
    out_ready = 1'b1;
    drive(ALU_ADDU, 32'd200, 32'd2, 5'd0, 1'b0, 5'd10, 5'd0, 5'd0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_drop",  result,             32'd101);
    step();
    check("flush_stays", {31'd0, out_valid}, 32'd0);

    // Reset while stalled discards the held instruction
    out_ready = 1'b0;
    issue(ALU_ADDU, 32'd7, 32'd7, 5'd0, 1'b0, 5'd11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_stall_valid", {31'd0, out_valid}, 32'd0);
    check("rst_stall_res",   result,             32'd0);
    check("rst_stall_ready", {31'd0, in_ready},  32'd1);
    out_ready = 1'b1;

`ifdef ALU_EX_FWD_EN
    // Forward from the held result into operand A
    drive(ALU_ADDU, 32'd4, 32'd6, 5'd0, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0);
    step();
    drive(ALU_ADDU, 32'd0, 32'd1, 5'd0, 1'b0, 5'd12, 5'd5, 5'd0, 1'b0);
    step();
    in_valid = 1'b0;
    check("fwd_a", result, 32'd11);
    step();
    // No forwarding from register zero
    drive(ALU_ADDU, 32'd4, 32'd6, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    step();
    drive(ALU_ADDU, 32'd0, 32'd1, 5'd0, 1'b0, 5'd12, 5'd0, 5'd0, 1'b0);
    step();
    in_valid = 1'b0;
    check("fwd_r0", result, 32'd1);
    step();
    // Forward into operand B only when it is a register
    drive(ALU_ADDU, 32'd4, 32'd6, 5'd0, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0);
    step();
    drive(ALU_SUBU, 32'd20, 32'd0, 5'd0, 1'b0, 5'd12, 5'd0, 5'd5, 1'b1);
    step();
    in_valid = 1'b0;
    check("fwd_b", result, 32'd10);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
